i2c_generador: RTL and testbench

- I2C master transaction generator that drives the slave receiver stage: produces SCL, SDA_out and SDA_oe, and samples SDA_in.
- One request runs one complete 16-bit transaction:
  - START, 7-bit address, R/W bit, address ACK.
  - Two data bytes, MSB first, each followed by an ACK slot.
  - STOP.
- Sits between the register-access host and the I2C slave. The host sees a simple start/busy/done handshake.

---
 rtl/i2c_generador_pkg.sv | 28 ++
 rtl/i2c_generador_if.sv | 25 ++
 rtl/i2c_generador_scl_div.sv | 39 +++
 rtl/i2c_generador.sv | 190 +++++++++++++++++++
 tb/tb_i2c_generador.sv | 272 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/i2c_generador_pkg.sv
// Shared definitions for the I2C transaction generator: FSM states, SCL
// quarter-phases, ACK/NACK line levels and the address/data widths.
package i2c_pkg;

    localparam int ADDR_W = 7;
    localparam int DATA_W = 16;

    localparam logic ACK_BIT  = 1'b0;
    localparam logic NACK_BIT = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        START,
        ADDR,
        ADDR_ACK,
        DATA,
        DATA_ACK,
        STOP
    } state_t;

    typedef enum logic [1:0] {
        Q0,
        Q1,
        Q2,
        Q3
    } phase_t;

endpackage

// File: rtl/i2c_generador_if.sv
// Host-side handshake of the I2C transaction generator. The host uses the
// master modport, the generator itself uses the slave modport.
interface i2c_generador_if;
    import i2c_pkg::*;

    logic              Start_stb;
    logic              Rnw;
    logic [ADDR_W-1:0] I2c_addr;
    logic [DATA_W-1:0] Wr_data;
    logic [DATA_W-1:0] Rd_data;
    logic              Busy;
    logic              Done;
    logic              Nack;

    modport master (
        output Start_stb, Rnw, I2c_addr, Wr_data,
        input  Rd_data, Busy, Done, Nack
    );

    modport slave (
        input  Start_stb, Rnw, I2c_addr, Wr_data,
        output Rd_data, Busy, Done, Nack
    );

endinterface

// File: rtl/i2c_generador_scl_div.sv
// SCL divider: splits every SCL period into four quarter-phases of CLK_DIV
// CLK cycles each. phase_tick marks the last CLK of the current phase.
module i2c_scl_div
    import i2c_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic   CLK,
    input  logic   Reset,
    input  logic   enable,
    output logic   phase_tick,
    output phase_t phase,
    output logic   scl
);

    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [CW-1:0] div_cnt;
    phase_t        phase_q;

    assign phase_tick = enable && (div_cnt == CW'(CLK_DIV - 1));
    assign phase      = phase_q;
    assign scl        = (phase_q != Q0);

    // Divider and phase counter; held at the start of Q0 while idle so every
    // transaction begins on a clean phase boundary.
    always_ff @(posedge CLK) begin
        if (Reset || !enable) begin
            div_cnt <= '0;
            phase_q <= Q0;
        end else if (phase_tick) begin
            div_cnt <= '0;
            phase_q <= phase_t'(phase_q + 2'd1);
        end else begin
            div_cnt <= div_cnt + CW'(1);
        end
    end

endmodule

// File: rtl/i2c_generador.sv
// I2C master transaction generator: START, {addr,rnw}, ACK, two data bytes
// each with an ACK slot, STOP. Optional macro I2C_NACK_ABORT_EN makes a NACK
// on the address or on a written byte cut straight to STOP.
module i2c_generador
    import i2c_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic           CLK,
    input  logic           Reset,
    i2c_generador_if.slave host,
    input  logic           SDA_in,
    output logic           SCL,
    output logic           SDA_out,
    output logic           SDA_oe
);

    state_t            state_q, state_d;
    logic [2:0]        bit_cnt_q, bit_cnt_d;
    logic              byte_idx_q, byte_idx_d;
    logic [7:0]        addr_byte_q;
    logic [DATA_W-1:0] wr_data_q;
    logic [DATA_W-1:0] rd_data_q;
    logic              nack_q;
    logic              done_q;

    logic   phase_tick;
    phase_t phase;
    logic   div_scl;
    logic   period_end;
    logic   sample_en;
    logic   scl_force;
    logic   is_read;
    logic   abort_now;

    i2c_scl_div #(
        .CLK_DIV(CLK_DIV)
    ) u_div (
        .CLK       (CLK),
        .Reset     (Reset),
        .enable    (state_q != IDLE),
        .phase_tick(phase_tick),
        .phase     (phase),
        .scl       (div_scl)
    );

    assign period_end = phase_tick && (phase == Q3);
    assign sample_en  = phase_tick && (phase == Q2);
    assign is_read    = addr_byte_q[0];

`ifdef I2C_NACK_ABORT_EN
    assign abort_now = nack_q;
`else
    assign abort_now = 1'b0;
`endif

    // State register together with the bit and byte counters.
    always_ff @(posedge CLK) begin
        if (Reset) begin
            state_q    <= IDLE;
            bit_cnt_q  <= 3'd0;
            byte_idx_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            byte_idx_q <= byte_idx_d;
        end
    end

    // Next state, counters and the SDA/SCL drive for the current slot.
    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        byte_idx_d = byte_idx_q;
        SDA_out    = 1'b1;
        SDA_oe     = 1'b1;
        scl_force  = 1'b0;
        unique case (state_q)
            IDLE: begin
                scl_force = 1'b1;
                if (host.Start_stb) begin
                    state_d = START;
                end
            end
            START: begin
                scl_force = 1'b1;
                SDA_out   = (phase == Q0) || (phase == Q1);
                if (period_end) begin
                    state_d   = ADDR;
                    bit_cnt_d = 3'd0;
                end
            end
            ADDR: begin
                SDA_out = addr_byte_q[3'd7 - bit_cnt_q];
                if (period_end) begin
                    if (bit_cnt_q == 3'd7) begin
                        state_d = ADDR_ACK;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                    end
                end
            end
            ADDR_ACK: begin
                SDA_oe = 1'b0;
                if (period_end) begin
                    if (abort_now) begin
                        state_d = STOP;
                    end else begin
                        state_d    = DATA;
                        byte_idx_d = 1'b0;
                        bit_cnt_d  = 3'd0;
                    end
                end
            end
            DATA: begin
                if (is_read) begin
                    SDA_oe = 1'b0;
                end else begin
                    SDA_out = wr_data_q[4'd15 - {byte_idx_q, bit_cnt_q}];
                end
                if (period_end) begin
                    if (bit_cnt_q == 3'd7) begin
                        state_d = DATA_ACK;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                    end
                end
            end
            DATA_ACK: begin
                if (is_read) begin
                    SDA_out = byte_idx_q ? NACK_BIT : ACK_BIT;
                end else begin
                    SDA_oe = 1'b0;
                end
                if (period_end) begin
                    if (byte_idx_q || (!is_read && abort_now)) begin
                        state_d = STOP;
                    end else begin
                        state_d    = DATA;
                        byte_idx_d = 1'b1;
                        bit_cnt_d  = 3'd0;
                    end
                end
            end
            STOP: begin
                SDA_out = (phase == Q2) || (phase == Q3);
                if (period_end) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Request latching, slave ACK checking, read shifting and the Done pulse.
    always_ff @(posedge CLK) begin
        if (Reset) begin
            addr_byte_q <= 8'd0;
            wr_data_q   <= '0;
            rd_data_q   <= '0;
            nack_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            done_q <= (state_q == STOP) && period_end;
            if ((state_q == IDLE) && host.Start_stb) begin
                addr_byte_q <= {host.I2c_addr, host.Rnw};
                wr_data_q   <= host.Wr_data;
                nack_q      <= 1'b0;
            end
            if (sample_en) begin
                if (((state_q == ADDR_ACK) || ((state_q == DATA_ACK) && !is_read))
                    && (SDA_in == NACK_BIT)) begin
                    nack_q <= 1'b1;
                end
                if ((state_q == DATA) && is_read) begin
                    rd_data_q <= {rd_data_q[DATA_W-2:0], SDA_in};
                end
            end
        end
    end

    assign SCL          = scl_force ? 1'b1 : div_scl;
    assign host.Busy    = (state_q != IDLE);
    assign host.Done    = done_q;
    assign host.Nack    = nack_q;
    assign host.Rd_data = rd_data_q;

endmodule

// File: tb/tb_i2c_generador.sv
// Testbench for i2c_generador: a behavioural I2C slave decodes the bus from
// SCL/SDA edges, and every transaction is checked against values derived
// from the request and the slave's configured responses.
module tb_i2c_generador;
    import i2c_pkg::*;

    localparam int CLK_DIV = 4;
    localparam int PERIOD  = 4 * CLK_DIV;

    logic CLK = 1'b0;
    logic Reset;
    logic SDA_in;
    logic SCL, SDA_out, SDA_oe;

    i2c_generador_if hif();

    i2c_generador #(.CLK_DIV(CLK_DIV)) dut (
        .CLK    (CLK),
        .Reset  (Reset),
        .host   (hif),
        .SDA_in (SDA_in),
        .SCL    (SCL),
        .SDA_out(SDA_out),
        .SDA_oe (SDA_oe)
    );

    always #5 CLK = ~CLK;

    int checks   = 0;
    int failures = 0;

    // Slave configuration and observations
    logic        cfg_addr_nack = 1'b0;
    logic        cfg_data_nack = 1'b0;
    logic [15:0] cfg_rd_word   = 16'h0000;
    logic        sl_bits [0:31];
    int          sl_nbits      = 0;
    int          sl_frame_bits = 0;
    int          sl_starts     = 0;
    int          sl_stops      = 0;
    logic        prev_scl      = 1'b1;
    logic        prev_sda      = 1'b1;
    int          done_cnt      = 0;

    // Transaction observations and reference state
    logic        obs_seen;
    int          obs_busy;
    logic [15:0] obs_rd;
    logic        obs_nack;
    int          starts0, stops0, done0;
    logic [15:0] rd_model = 16'h0000;

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
        end
    endtask

    // What the slave puts on SDA for frame slot k (0..7 addr, 8 ack, ...)
    function automatic logic slaveDrive(input int k);
        logic rnw;
        rnw = sl_bits[7];
        if (k == 8) return cfg_addr_nack;
        if (k >= 9 && k <= 16) return (rnw && !cfg_addr_nack) ? cfg_rd_word[15-(k-9)] : 1'b1;
        if (k >= 18 && k <= 25) return (rnw && !cfg_addr_nack) ? cfg_rd_word[7-(k-18)] : 1'b1;
        if (k == 17 || k == 26) return rnw ? 1'b1 : cfg_data_nack;
        return 1'b1;
    endfunction

    function automatic logic [7:0] frameByte(input int first);
        logic [7:0] b;
        for (int i = 0; i < 8; i++) b[7-i] = sl_bits[first+i];
        return b;
    endfunction

    // Behavioural slave plus START/STOP detector on the wired-AND bus line
    always @(negedge CLK) begin
        logic line;
        line = SDA_oe ? SDA_out : SDA_in;
        if (Reset) begin
            SDA_in   = 1'b1;
            sl_nbits = 0;
        end else if (prev_scl && SCL && (line != prev_sda)) begin
            if (line == 1'b0) begin
                sl_starts++;
                sl_nbits = 0;
            end else begin
                sl_stops++;
                sl_frame_bits = sl_nbits - 1;
                SDA_in = 1'b1;
            end
        end else if (!prev_scl && SCL) begin
            if (sl_nbits < 32) sl_bits[sl_nbits] = line;
            sl_nbits++;
        end else if (prev_scl && !SCL) begin
            SDA_in = slaveDrive(sl_nbits);
        end
        prev_scl = SCL;
        prev_sda = line;
    end

    // Done pulse counter
    always @(negedge CLK) begin
        if (hif.Done === 1'b1) done_cnt++;
    end

    // Issue one request and wait (bounded) for Done; optionally pulse a
    // conflicting Start_stb while the transaction is running.
    task automatic applyStimulus(input logic rnw, input logic [6:0] addr,
                                 input logic [15:0] wdata, input logic [15:0] rdword,
                                 input logic anack, input logic dnack, input bit dup);
        cfg_addr_nack = anack;
        cfg_data_nack = dnack;
        cfg_rd_word   = rdword;
        @(negedge CLK);
        starts0 = sl_starts;
        stops0  = sl_stops;
        done0   = done_cnt;
        hif.Start_stb = 1'b1;
        hif.Rnw       = rnw;
        hif.I2c_addr  = addr;
        hif.Wr_data   = wdata;
        @(negedge CLK);
        hif.Start_stb = 1'b0;
        checkOutput("busy_after_start", {31'd0, hif.Busy}, 32'd1);
        obs_busy = 0;
        obs_seen = 1'b0;
        for (int i = 0; i < 20000 && !obs_seen; i++) begin
            if (hif.Busy) obs_busy++;
            if (dup && obs_busy == 40) begin
                hif.Start_stb = 1'b1;
                hif.Rnw       = ~rnw;
                hif.I2c_addr  = ~addr;
                hif.Wr_data   = ~wdata;
            end else begin
                hif.Start_stb = 1'b0;
            end
            @(negedge CLK);
            if (hif.Done) begin
                obs_seen = 1'b1;
                obs_rd   = hif.Rd_data;
                obs_nack = hif.Nack;
            end
        end
        hif.Start_stb = 1'b0;
        repeat (2 * PERIOD) @(negedge CLK);
    endtask

    // Expected results from the request and slave behaviour alone
    task automatic checkTransaction(input logic rnw, input logic [6:0] addr,
                                    input logic [15:0] wdata);
        logic exp_nack;
        int   exp_bits;
        exp_nack = cfg_addr_nack || (!rnw && cfg_data_nack);
`ifdef I2C_NACK_ABORT_EN
        exp_bits = cfg_addr_nack ? 9 : ((!rnw && cfg_data_nack) ? 18 : 27);
`else
        exp_bits = 27;
`endif
        if (rnw && exp_bits == 27) rd_model = cfg_addr_nack ? 16'hFFFF : cfg_rd_word;
        checkOutput("done_seen", {31'd0, obs_seen}, 32'd1);
        checkOutput("busy_cycles", obs_busy, (exp_bits + 2) * PERIOD);
        checkOutput("done_count", done_cnt - done0, 32'd1);
        checkOutput("nack", {31'd0, obs_nack}, {31'd0, exp_nack});
        checkOutput("rd_data", {16'd0, obs_rd}, {16'd0, rd_model});
        checkOutput("start_cond", sl_starts - starts0, 32'd1);
        checkOutput("stop_cond", sl_stops - stops0, 32'd1);
        checkOutput("frame_bits", sl_frame_bits, exp_bits);
        checkOutput("addr_byte", {24'd0, frameByte(0)}, {24'd0, addr, rnw});
        checkOutput("addr_ack", {31'd0, sl_bits[8]}, {31'd0, cfg_addr_nack});
        if (exp_bits == 27) begin
            if (rnw) begin
                checkOutput("master_ack0", {31'd0, sl_bits[17]}, 32'd0);
                checkOutput("master_nack1", {31'd0, sl_bits[26]}, 32'd1);
            end else begin
                checkOutput("data_byte0", {24'd0, frameByte(9)}, {24'd0, wdata[15:8]});
                checkOutput("data_byte1", {24'd0, frameByte(18)}, {24'd0, wdata[7:0]});
            end
        end
    endtask

    task automatic runOne(input logic rnw, input logic [6:0] addr, input logic [15:0] wdata,
                          input logic [15:0] rdword, input logic anack, input logic dnack,
                          input bit dup);
        applyStimulus(rnw, addr, wdata, rdword, anack, dnack, dup);
        checkTransaction(rnw, addr, wdata);
    endtask

    // Watchdog
    initial begin
        #5ms;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int waited;
        hif.Start_stb = 1'b0;
        hif.Rnw       = 1'b0;
        hif.I2c_addr  = 7'd0;
        hif.Wr_data   = 16'd0;
        Reset = 1'b1;
        repeat (3) @(negedge CLK);
        Reset = 1'b0;
        @(negedge CLK);
        $display("[TB] reset values");
        checkOutput("rst_scl", {31'd0, SCL}, 32'd1);
        checkOutput("rst_sda_out", {31'd0, SDA_out}, 32'd1);
        checkOutput("rst_sda_oe", {31'd0, SDA_oe}, 32'd1);
        checkOutput("rst_busy", {31'd0, hif.Busy}, 32'd0);
        checkOutput("rst_done", {31'd0, hif.Done}, 32'd0);
        checkOutput("rst_nack", {31'd0, hif.Nack}, 32'd0);
        checkOutput("rst_rd_data", {16'd0, hif.Rd_data}, 32'd0);

        $display("[TB] directed transactions");
        runOne(1'b0, 7'h2A, 16'hA5C3, 16'h0000, 1'b0, 1'b0, 1'b0);
        runOne(1'b1, 7'h2A, 16'h0000, 16'h3C96, 1'b0, 1'b0, 1'b0);
        runOne(1'b0, 7'h2A, 16'h1111, 16'h0000, 1'b1, 1'b0, 1'b0);
        runOne(1'b0, 7'h15, 16'h1234, 16'h0000, 1'b0, 1'b0, 1'b1);
        runOne(1'b0, 7'h40, 16'h5AA5, 16'h0000, 1'b0, 1'b1, 1'b0);

        $display("[TB] reset during data byte 0");
        cfg_addr_nack = 1'b0;
        cfg_data_nack = 1'b0;
        @(negedge CLK);
        hif.Start_stb = 1'b1;
        hif.Rnw       = 1'b0;
        hif.I2c_addr  = 7'h33;
        hif.Wr_data   = 16'hF00D;
        @(negedge CLK);
        hif.Start_stb = 1'b0;
        waited = 0;
        while (sl_nbits < 12 && waited < 5000) begin
            @(negedge CLK);
            waited++;
        end
        checkOutput("reached_data0", {31'd0, (sl_nbits >= 12)}, 32'd1);
        Reset = 1'b1;
        @(negedge CLK);
        checkOutput("mid_rst_scl", {31'd0, SCL}, 32'd1);
        checkOutput("mid_rst_sda_out", {31'd0, SDA_out}, 32'd1);
        checkOutput("mid_rst_sda_oe", {31'd0, SDA_oe}, 32'd1);
        checkOutput("mid_rst_busy", {31'd0, hif.Busy}, 32'd0);
        checkOutput("mid_rst_done", {31'd0, hif.Done}, 32'd0);
        Reset = 1'b0;
        rd_model = 16'h0000;
        repeat (4) @(negedge CLK);
        runOne(1'b0, 7'h33, 16'hF00D, 16'h0000, 1'b0, 1'b0, 1'b0);

        $display("[TB] randomized transactions");
        for (int t = 0; t < 10; t++) begin
            logic        r_rnw;
            logic [6:0]  r_addr;
            logic [15:0] r_wdata, r_rword;
            logic        r_an, r_dn;
            r_rnw   = 1'($urandom_range(0, 1));
            r_addr  = 7'($urandom);
            r_wdata = 16'($urandom);
            r_rword = 16'($urandom);
            r_an    = ($urandom_range(0, 3) == 0);
            r_dn    = ($urandom_range(0, 3) == 0);
            runOne(r_rnw, r_addr, r_wdata, r_rword, r_an, r_dn, 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
